riscv_cpu_core: RTL and testbench
=================================

// Module: riscv_cpu_core
// PURPOSE
// - Multi-cycle RV32I integer core (control unit + 32x32 register file).
// - Talks to one external memory block through a request port (CtlToMem) and a response port (MemToCtl).
// - Uses the same port for instruction fetch and for data load/store; one outstanding transaction at a time.
// - Sits beside the Memory block at subsystem top; no caches, no interrupts, no CSRs.
// PARAMETERS
// - RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
// - clk                   in   1    single clock, rising edge
// - rst                   in   1    asynchronous, active-low reset
// - MemToCtl_port         in   32   MEtoCU_IF {loadedData[31:0]}, fetched word or load result
// - MemToCtl_port_sync    in   1    memory offers valid MemToCtl_port data
// - MemToCtl_port_notify  out  1    core ready to consume response
// - CtlToMem_port         out  69   CUtoME_IF {addrIn[31:0], dataIn[31:0], mask[2:0], req[1:0]}
// - CtlToMem_port_sync    in   1    memory ready to accept request
// - CtlToMem_port_notify  out  1    core presents valid request
// BEHAVIOUR
// - Handshake: a transfer occurs in the cycle both sync and notify are high.
//   - Data and notify hold stable until that cycle; notify drops the cycle after.
// - Reset (rst=0, async):
//   - PC=RESET_PC, all regs 0, both notify outputs 0.
//   - CtlToMem_port = {0, 0, MT_X, ME_X}.
//   - Core state -> FETCH_REQ. Reset mid-transaction abandons it.
// - State machine:
//   - FETCH_REQ: drive {PC, 0, MT_W, ME_RD}; on transfer -> FETCH_RSP.
//   - FETCH_RSP: notify=1; on transfer latch IR=loadedData -> EXEC.
//   - EXEC (1 cycle): decode IR.
//     - ALU, LUI, AUIPC, JAL, JALR, branches: write rd, update PC -> FETCH_REQ.
//     - Loads -> MEM_REQ with ME_RD; stores -> MEM_REQ with ME_WR.
//   - MEM_REQ: drive {rs1+imm, rs2, mask, req}; on transfer: store -> FETCH_REQ (PC+=4); load -> MEM_RSP.
//   - MEM_RSP: on transfer write rd=loadedData; PC+=4 -> FETCH_REQ.
// - Masks:
//   - LB=MT_B, LBU=MT_BU, LH=MT_H, LHU=MT_HU, LW/SW=MT_W, SB=MT_B, SH=MT_H.
//   - Memory performs sign/zero extension; core writes loadedData unmodified.
// - Arithmetic: 32-bit wrap-around, no overflow flags.
//   - Shifts use rs2[4:0]/shamt; SRA arithmetic.
//   - SLT signed; SLTU unsigned.
// - Control flow:
//   - JAL/JALR link PC+4; JALR target (rs1+imm)&~1.
//   - Branch taken: PC+imm; not taken: PC+4.
// - x0 reads 0 always; writes to x0 discarded.
// - FENCE, ECALL, EBREAK (0x00100073), unknown opcodes: NOP, PC+=4.
// - No alignment checking: addresses pass to memory unchanged; PC wraps at 2^32.
// STRUCTURE
// - Package top_level_types:
//   - MEtoCU_IF, CUtoME_IF structs.
//   - ME_MaskType enum {MT_B, MT_BU, MT_H, MT_HU, MT_W, MT_X}, 3 bits.
//   - ME_AccessType enum {ME_RD, ME_WR, ME_X}, 2 bits.
//   - Opcode/funct3 localparams.
// - One sub-module: riscv_alu (combinational; op select, a, b -> result, branch compare).
// - Register file and FSM live in the core.
// TESTING
// - Reset:
//   - Hold rst=0 two cycles, release -> CtlToMem_port_notify=1, addrIn=0, req=ME_RD, mask=MT_W.
// - Handshake stall:
//   - Keep CtlToMem_port_sync=0 5 cycles -> request held stable; advances only on sync.
// - ALU + store:
//   - Feed ADDI x1,x0,5 then SW x1,0x100(x0) -> request {0x100, 5, MT_W, ME_WR}; next fetch addr 8.
// - Load:
//   - LW x2,0x100(x0) with loadedData=0xDEADBEEF, then SW x2,4(x0) -> store dataIn=0xDEADBEEF.
// - Branch/jump:
//   - BEQ x0,x0,+16 at 0x20 -> next fetch 0x30.
//   - JAL x1,-8 at 0x40 -> fetch 0x38 and x1=0x44.
// - EBREAK:
//   - Fetch returns 0x00100073 (1048691) -> no register/memory effect; next fetch at PC+4.

Source files
------------

// File: rtl/riscv_cpu_core_pkg.sv
// rtl/riscv_cpu_core_pkg.sv - shared types, opcodes and ALU decode for the RV32I core
package top_level_types;

    typedef enum logic [2:0] {MT_B, MT_BU, MT_H, MT_HU, MT_W, MT_X} ME_MaskType;
    typedef enum logic [1:0] {ME_RD, ME_WR, ME_X} ME_AccessType;

    typedef struct packed {
        logic [31:0] loadedData;
    } MEtoCU_IF;

    typedef struct packed {
        logic [31:0]  addrIn;
        logic [31:0]  dataIn;
        ME_MaskType   mask;
        ME_AccessType req;
    } CUtoME_IF;

    typedef enum logic [2:0] {FETCH_REQ, FETCH_RSP, EXEC, MEM_REQ, MEM_RSP} CoreState;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } AluOp;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // alt selects SUB/SRA; the caller only raises it where funct7 is meaningful
    function automatic AluOp decodeAluOp(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_cpu_core_if.sv
// rtl/riscv_cpu_core_if.sv - request/response memory port bundle between core and memory
interface riscv_cpu_core_if;
    import top_level_types::*;

    MEtoCU_IF MemToCtl_port;
    logic     MemToCtl_port_sync;
    logic     MemToCtl_port_notify;
    CUtoME_IF CtlToMem_port;
    logic     CtlToMem_port_sync;
    logic     CtlToMem_port_notify;

    modport master (
        input  MemToCtl_port, MemToCtl_port_sync, CtlToMem_port_sync,
        output MemToCtl_port_notify, CtlToMem_port, CtlToMem_port_notify
    );

    modport slave (
        output MemToCtl_port, MemToCtl_port_sync, CtlToMem_port_sync,
        input  MemToCtl_port_notify, CtlToMem_port, CtlToMem_port_notify
    );
endinterface

// File: rtl/riscv_cpu_core_alu.sv
// rtl/riscv_cpu_core_alu.sv - combinational RV32I ALU with branch comparator
module riscv_alu
    import top_level_types::*;
(
    input  AluOp        aluOp,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  brFunct3,
    output logic [31:0] result,
    output logic        brTaken
);

    always_comb begin
        result = '0;
        case (aluOp)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        brTaken = 1'b0;
        case (brFunct3)
            3'b000:  brTaken = (a == b);
            3'b001:  brTaken = (a != b);
            3'b100:  brTaken = ($signed(a) < $signed(b));
            3'b101:  brTaken = ($signed(a) >= $signed(b));
            3'b110:  brTaken = (a < b);
            3'b111:  brTaken = (a >= b);
            default: brTaken = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_cpu_core.sv
// rtl/riscv_cpu_core.sv - multi-cycle RV32I core sharing one memory port for fetch and data
module riscv_cpu_core
    import top_level_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    riscv_cpu_core_if.master  memBus
);

    CoreState    state, nextState;
    logic [31:0] pc, ir;
    logic [31:0] regFile [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1Idx, rs2Idx;
    logic [2:0]  funct3;
    logic [31:0] rs1Val, rs2Val;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic        isLoad, isStore, isOp, isBranch;
    logic [31:0] pcPlus4, jalrSum, memAddr;
    ME_MaskType  memMask;

    AluOp        aluOp;
    logic [31:0] aluB, aluResult;
    logic        brTaken;

    logic        execWrEn, wrEn;
    logic [31:0] execWrData, execNextPc, wrData;

    logic reqFire, rspFire;
    assign reqFire = memBus.CtlToMem_port_sync  && memBus.CtlToMem_port_notify;
    assign rspFire = memBus.MemToCtl_port_sync  && memBus.MemToCtl_port_notify;

    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign funct3   = ir[14:12];
    assign rs1Idx   = ir[19:15];
    assign rs2Idx   = ir[24:20];
    assign rs1Val   = (rs1Idx == 5'd0) ? 32'd0 : regFile[rs1Idx];
    assign rs2Val   = (rs2Idx == 5'd0) ? 32'd0 : regFile[rs2Idx];

    assign immI = {{20{ir[31]}}, ir[31:20]};
    assign immS = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign immU = {ir[31:12], 12'b0};
    assign immJ = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign isLoad   = (opcode == OPC_LOAD);
    assign isStore  = (opcode == OPC_STORE);
    assign isOp     = (opcode == OPC_OP);
    assign isBranch = (opcode == OPC_BRANCH);
    assign pcPlus4  = pc + 32'd4;
    assign jalrSum  = rs1Val + immI;
    assign memAddr  = rs1Val + (isStore ? immS : immI);

    // ADDI with a negative immediate has bit 30 set, so alt only applies to R-type or shifts
    assign aluOp = decodeAluOp(funct3, ir[30] && (isOp || funct3 == 3'b101));
    assign aluB  = (isOp || isBranch) ? rs2Val : immI;

    riscv_alu alu (
        .aluOp    (aluOp),
        .a        (rs1Val),
        .b        (aluB),
        .brFunct3 (funct3),
        .result   (aluResult),
        .brTaken  (brTaken)
    );

    always_comb begin
        memMask = MT_W;
        case (funct3)
            F3_B:    memMask = MT_B;
            F3_H:    memMask = MT_H;
            F3_BU:   memMask = isLoad ? MT_BU : MT_W;
            F3_HU:   memMask = isLoad ? MT_HU : MT_W;
            default: memMask = MT_W;
        endcase
    end

    always_comb begin
        execWrEn   = 1'b0;
        execWrData = aluResult;
        execNextPc = pcPlus4;
        case (opcode)
            OPC_OP, OPC_OPIMM: execWrEn = 1'b1;
            OPC_LUI:   begin execWrEn = 1'b1; execWrData = immU;      end
            OPC_AUIPC: begin execWrEn = 1'b1; execWrData = pc + immU; end
            OPC_JAL: begin
                execWrEn   = 1'b1;
                execWrData = pcPlus4;
                execNextPc = pc + immJ;
            end
            OPC_JALR: begin
                execWrEn   = 1'b1;
                execWrData = pcPlus4;
                execNextPc = {jalrSum[31:1], 1'b0};
            end
            OPC_BRANCH: execNextPc = brTaken ? pc + immB : pcPlus4;
            default: ;
        endcase
    end

    assign wrEn   = (state == EXEC && execWrEn) || (state == MEM_RSP && rspFire);
    assign wrData = (state == MEM_RSP) ? memBus.MemToCtl_port.loadedData : execWrData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (wrEn && rd != 5'd0) begin
            regFile[rd] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            case (state)
                FETCH_RSP: if (rspFire) ir <= memBus.MemToCtl_port.loadedData;
                EXEC:      if (!isLoad && !isStore) pc <= execNextPc;
                MEM_REQ:   if (reqFire && isStore) pc <= pcPlus4;
                MEM_RSP:   if (rspFire) pc <= pcPlus4;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH_REQ;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH_REQ: if (reqFire) nextState = FETCH_RSP;
            FETCH_RSP: if (rspFire) nextState = EXEC;
            EXEC:      nextState = (isLoad || isStore) ? MEM_REQ : FETCH_REQ;
            MEM_REQ:   if (reqFire) nextState = isStore ? FETCH_REQ : MEM_RSP;
            MEM_RSP:   if (rspFire) nextState = FETCH_REQ;
            default:   nextState = FETCH_REQ;
        endcase
    end

    // outputs are gated by rst so the port is idle while reset is asserted
    always_comb begin
        memBus.CtlToMem_port        = '{addrIn: 32'd0, dataIn: 32'd0, mask: MT_X, req: ME_X};
        memBus.CtlToMem_port_notify = 1'b0;
        memBus.MemToCtl_port_notify = 1'b0;
        if (rst) begin
            case (state)
                FETCH_REQ: begin
                    memBus.CtlToMem_port        = '{addrIn: pc, dataIn: 32'd0, mask: MT_W, req: ME_RD};
                    memBus.CtlToMem_port_notify = 1'b1;
                end
                MEM_REQ: begin
                    memBus.CtlToMem_port        = '{addrIn: memAddr, dataIn: rs2Val, mask: memMask,
                                                    req: isStore ? ME_WR : ME_RD};
                    memBus.CtlToMem_port_notify = 1'b1;
                end
                FETCH_RSP, MEM_RSP: memBus.MemToCtl_port_notify = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_cpu_core.sv
// tb/tb_riscv_cpu_core.sv - directed-vector bench for riscv_cpu_core
module tb_riscv_cpu_core;
    import top_level_types::*;

    logic clk = 1'b0;
    logic rst;
    int   numCompared   = 0;
    int   numMismatched = 0;

    riscv_cpu_core_if memBus ();

    riscv_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .memBus (memBus)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic serveRequest(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                input ME_MaskType mask, input ME_AccessType req, input bit chkData);
        for (int i = 0; i < 50 && !memBus.CtlToMem_port_notify; i++) @(negedge clk);
        checkValue({tag, "_notify"}, 32'(memBus.CtlToMem_port_notify), 32'd1);
        checkValue({tag, "_addr"}, memBus.CtlToMem_port.addrIn, addr);
        if (chkData) checkValue({tag, "_data"}, memBus.CtlToMem_port.dataIn, data);
        checkValue({tag, "_mask"}, 32'(memBus.CtlToMem_port.mask), 32'(mask));
        checkValue({tag, "_req"}, 32'(memBus.CtlToMem_port.req), 32'(req));
        memBus.CtlToMem_port_sync = 1'b1;
        @(posedge clk);
        #1 memBus.CtlToMem_port_sync = 1'b0;
        @(negedge clk);
        if (req == ME_RD)
            checkValue({tag, "_drop"}, 32'(memBus.CtlToMem_port_notify), 32'd0);
    endtask

    task automatic serveResponse(input string tag, input logic [31:0] data);
        for (int i = 0; i < 50 && !memBus.MemToCtl_port_notify; i++) @(negedge clk);
        checkValue({tag, "_rspnotify"}, 32'(memBus.MemToCtl_port_notify), 32'd1);
        memBus.MemToCtl_port.loadedData = data;
        memBus.MemToCtl_port_sync       = 1'b1;
        @(posedge clk);
        #1 memBus.MemToCtl_port_sync = 1'b0;
    endtask

    task automatic serveFetch(input logic [31:0] addr, input logic [31:0] instr);
        string tag;
        tag = $sformatf("fetch%0h", addr);
        serveRequest(tag, addr, 32'd0, MT_W, ME_RD, 1'b1);
        serveResponse(tag, instr);
    endtask

    task automatic serveStore(input logic [31:0] addr, input logic [31:0] data, input ME_MaskType mask);
        serveRequest($sformatf("store%0h", addr), addr, data, mask, ME_WR, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        memBus.CtlToMem_port_sync       = 1'b0;
        memBus.MemToCtl_port_sync       = 1'b0;
        memBus.MemToCtl_port.loadedData = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("rst_reqnotify", 32'(memBus.CtlToMem_port_notify), 32'd0);
        checkValue("rst_rspnotify", 32'(memBus.MemToCtl_port_notify), 32'd0);
        checkValue("rst_mask", 32'(memBus.CtlToMem_port.mask), 32'(MT_X));
        checkValue("rst_req", 32'(memBus.CtlToMem_port.req), 32'(ME_X));
        checkValue("rst_addr", memBus.CtlToMem_port.addrIn, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkValue("stall_notify", 32'(memBus.CtlToMem_port_notify), 32'd1);
            checkValue("stall_addr", memBus.CtlToMem_port.addrIn, 32'd0);
            checkValue("stall_req", 32'(memBus.CtlToMem_port.req), 32'(ME_RD));
        end

        serveFetch(32'h00, 32'h0050_0093);               // ADDI x1,x0,5
        serveFetch(32'h04, 32'h1010_2023);               // SW x1,0x100(x0)
        serveStore(32'h100, 32'd5, MT_W);
        serveFetch(32'h08, 32'h1000_2103);               // LW x2,0x100(x0)
        serveRequest("load100", 32'h100, 32'd0, MT_W, ME_RD, 1'b0);
        serveResponse("load100", 32'hDEAD_BEEF);
        serveFetch(32'h0C, 32'h0020_2223);               // SW x2,4(x0)
        serveStore(32'h004, 32'hDEAD_BEEF, MT_W);
        serveFetch(32'h10, 32'h0100_006F);               // JAL x0,+16
        serveFetch(32'h20, 32'h0000_0863);               // BEQ x0,x0,+16
        serveFetch(32'h30, 32'h0100_006F);               // JAL x0,+16
        serveFetch(32'h40, 32'hFF9F_F0EF);               // JAL x1,-8
        serveFetch(32'h38, 32'h0010_2023);               // SW x1,0(x0)
        serveStore(32'h000, 32'h44, MT_W);
        serveFetch(32'h3C, 32'h0010_0073);               // EBREAK
        serveFetch(32'h40, 32'h0020_0423);               // SB x2,8(x0)
        serveStore(32'h008, 32'hDEAD_BEEF, MT_B);
        serveFetch(32'h44, 32'hFFF0_0193);               // ADDI x3,x0,-1
        serveFetch(32'h48, 32'h01C1_D213);               // SRLI x4,x3,28
        serveFetch(32'h4C, 32'h0032_32B3);               // SLTU x5,x4,x3
        serveFetch(32'h50, 32'h0032_2333);               // SLT x6,x4,x3
        serveFetch(32'h54, 32'h0040_2023);               // SW x4,0(x0)
        serveStore(32'h000, 32'h0000_000F, MT_W);
        serveFetch(32'h58, 32'h0050_2023);               // SW x5,0(x0)
        serveStore(32'h000, 32'd1, MT_W);
        serveFetch(32'h5C, 32'h0060_2023);               // SW x6,0(x0)
        serveStore(32'h000, 32'd0, MT_W);
        serveFetch(32'h60, 32'h0070_0013);               // ADDI x0,x0,7
        serveFetch(32'h64, 32'h0000_2023);               // SW x0,0(x0)
        serveStore(32'h000, 32'd0, MT_W);
        serveRequest("fetch68", 32'h68, 32'd0, MT_W, ME_RD, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
